// File: rtl/network_sdiv_30s_14ns_16_seq.sv
// Sequential signed divider: 30-bit signed dividend / 14-bit unsigned divisor,
// radix-2 restoring, saturated 16-bit quotient plus signed remainder.
module network_sdiv_30s_14ns_16_seq #(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          din0_WIDTH = 30,
  parameter int          din1_WIDTH = 14,
  parameter int          dout_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH:0]   rem,
  output logic                  ovf,
  output logic                  dz
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [29:0] sh_q;      // dividend bits shift out the top, quotient bits shift in below
  logic [13:0] pr_q;
  logic [13:0] dvs_q;
  logic [4:0]  cnt_q;
  logic        neg_q, dzl_q;
  logic [15:0] dout_q;
  logic [14:0] rem_q;
  logic        ovf_q, dz_q;

  logic        unused_id;
  assign unused_id = ^ID;

  logic [29:0] mag;
  logic [14:0] pr_sh, pr_sub;
  logic        ge;
  logic [15:0] dout_d;
  logic [14:0] rem_d;
  logic        ovf_d;

  assign mag    = din0[29] ? (30'd0 - din0) : din0;
  assign pr_sh  = {pr_q, sh_q[29]};
  assign pr_sub = pr_sh - {1'b0, dvs_q};
  assign ge     = (pr_sh >= {1'b0, dvs_q});

  always_comb begin
    dout_d = 16'd0;
    rem_d  = 15'd0;
    ovf_d  = 1'b0;
    if (dzl_q) begin
      dout_d = neg_q ? 16'h8000 : 16'h7FFF;
    end else if (neg_q) begin
      // magnitude 32768 maps exactly onto -32768 without clipping
      ovf_d  = (sh_q > 30'd32768);
      dout_d = ovf_d ? 16'h8000 : (16'd0 - sh_q[15:0]);
      rem_d  = 15'd0 - {1'b0, pr_q};
    end else begin
      ovf_d  = (sh_q > 30'd32767);
      dout_d = ovf_d ? 16'h7FFF : sh_q[15:0];
      rem_d  = {1'b0, pr_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else if (ce) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: if (cnt_q == 5'd0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q   <= 30'd0;
      pr_q   <= 14'd0;
      dvs_q  <= 14'd0;
      cnt_q  <= 5'd0;
      neg_q  <= 1'b0;
      dzl_q  <= 1'b0;
      dout_q <= 16'd0;
      rem_q  <= 15'd0;
      ovf_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else if (ce) begin
      case (state_q)
        IDLE: if (in_valid) begin
          sh_q  <= mag;
          pr_q  <= 14'd0;
          dvs_q <= din1;
          cnt_q <= 5'd29;
          neg_q <= din0[29];
          dzl_q <= (din1 == 14'd0);
        end
        CALC: begin
          pr_q  <= ge ? pr_sub[13:0] : pr_sh[13:0];
          sh_q  <= {sh_q[28:0], ge};
          if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
        end
        FIX: begin
          dout_q <= dout_d;
          rem_q  <= rem_d;
          ovf_q  <= ovf_d;
          dz_q   <= dzl_q;
        end
        default: ;
      endcase
    end
  end

  assign dout = dout_q;
  assign rem  = rem_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule
